// File: rtl/image_pkg.sv
// Shared frame geometry, bus widths and FSM encodings for the SRAM frame-buffer
// reader and the capture-to-SRAM writer.
package image_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int FRAME_SIZE = IMG_W * IMG_H;
  localparam int ADDR_W     = 19;
  localparam int PIX_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous first-word-fall-through FIFO holding SRAM read data until
// the pixel consumer accepts it. The head is zero while empty.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && (count_reg != CW'(DEPTH));

  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge wclk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign empty = (count_reg == '0);
  assign rdata = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/image_out_sram.sv
// Streams one frame out of SRAM as a valid/ready pixel stream with x/y tags,
// keeping reads in flight bounded by the free space in the output FIFO.
module image_out_sram #(
  parameter int          IMG_W        = image_pkg::IMG_W,
  parameter int          IMG_H        = image_pkg::IMG_H,
  parameter logic [18:0] BASE_ADDR    = 19'd0,
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                          wclk,
  input  logic                          rst,
  input  logic                          enable,
  output logic                          selec_out_sram,
  output logic                          read_out_sram,
  output logic                          write_out_sram,
  output logic [image_pkg::ADDR_W-1:0]  addr_rd_out_sram,
  input  logic [image_pkg::PIX_W-1:0]   sram_rdata,
  output logic [image_pkg::PIX_W-1:0]   pix_data,
  output logic [8:0]                    pix_x,
  output logic [7:0]                    pix_y,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_last,
  output logic                          busy,
  output logic                          done
);

  import image_pkg::*;

  localparam int FRAME = IMG_W * IMG_H;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t                    state_reg, state_next;
  logic [ADDR_W-1:0]         index_reg;
  logic [ADDR_W-1:0]         addr_hold_reg;
  logic [ADDR_W-1:0]         addr_calc;
  logic [READ_LATENCY-1:0]   vld_sr_reg;
  logic [8:0]                x_reg;
  logic [7:0]                y_reg;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_empty;
  logic                      issue;
  logic                      last_issue;
  logic                      push;
  logic                      pop;
  int                        occupancy;

  // Slots already claimed: buffered pixels plus reads still in the SRAM pipe.
  always_comb begin
    occupancy = int'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) occupancy += int'(vld_sr_reg[i]);
  end

  assign issue      = (state_reg == S_READ) && (occupancy < FIFO_DEPTH);
  assign last_issue = issue && (index_reg == ADDR_W'(FRAME - 1));
  assign addr_calc  = BASE_ADDR + index_reg;
  assign push       = vld_sr_reg[READ_LATENCY-1];
  assign pop        = pix_valid && pix_ready;

  assign selec_out_sram   = issue;
  assign read_out_sram    = issue;
  assign write_out_sram   = 1'b0;
  assign addr_rd_out_sram = issue ? addr_calc : addr_hold_reg;

  assign pix_valid = !fifo_empty;
  assign pix_x     = x_reg;
  assign pix_y     = y_reg;
  assign pix_last  = pix_valid && (x_reg == 9'(IMG_W - 1)) && (y_reg == 8'(IMG_H - 1));
  assign busy      = (state_reg == S_READ) || (state_reg == S_DRAIN);
  assign done      = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (enable) state_next = S_READ;
      S_READ:  if (last_issue) state_next = S_DRAIN;
      S_DRAIN: if (pop && pix_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      index_reg     <= '0;
      addr_hold_reg <= '0;
      vld_sr_reg    <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
    end else begin
      state_reg     <= state_next;
      vld_sr_reg[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_sr_reg[i] <= vld_sr_reg[i-1];
      if (state_reg == S_IDLE) begin
        index_reg <= '0;
        x_reg     <= '0;
        y_reg     <= '0;
      end else begin
        if (issue) begin
          index_reg     <= index_reg + ADDR_W'(1);
          addr_hold_reg <= addr_calc;
        end
        if (pop) begin
          if (x_reg == 9'(IMG_W - 1)) begin
            x_reg <= '0;
            y_reg <= (y_reg == 8'(IMG_H - 1)) ? '0 : y_reg + 8'd1;
          end else begin
            x_reg <= x_reg + 9'd1;
          end
        end
      end
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .wclk  (wclk),
    .rst   (rst),
    .push  (push),
    .wdata (sram_rdata),
    .pop   (pop),
    .rdata (pix_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_image_out_sram.sv
// Directed bench for image_out_sram on a reduced 8x4 frame, with a second
// instance whose base address sits at the top of the SRAM address space.
module tb_image_out_sram;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        wclk = 1'b0;
  logic        rst, enable, enable_w, pix_ready;

  logic        selec, rd, wr, pix_valid, pix_last, busy, done;
  logic [18:0] addr;
  logic [15:0] sram_rdata, pix_data, p1, p2;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;

  logic        w_selec, w_rd, w_wr, w_valid, w_last, w_busy, w_done;
  logic [18:0] w_addr;
  logic [15:0] w_sram_rdata, w_data, q1, q2;
  logic [8:0]  w_x;
  logic [7:0]  w_y;

  logic [71:0] all_out, w_all_out;
  assign all_out   = {selec, rd, wr, addr, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done};
  assign w_all_out = {w_selec, w_rd, w_wr, w_addr, w_data, w_x, w_y, w_valid, w_last, w_busy, w_done};

  int checks = 0;
  int passes = 0;

  always #5 wclk = ~wclk;

  // SRAM models: two-cycle read pipe returning addr[15:0].
  always @(posedge wclk) begin
    p1 <= rd ? addr[15:0] : 16'hDEAD;
    p2 <= p1;
    q1 <= w_rd ? w_addr[15:0] : 16'hDEAD;
    q2 <= q1;
  end
  assign sram_rdata   = p2;
  assign w_sram_rdata = q2;

  image_out_sram #(.IMG_W(W), .IMG_H(H)) dut (
    .wclk(wclk), .rst(rst), .enable(enable),
    .selec_out_sram(selec), .read_out_sram(rd), .write_out_sram(wr),
    .addr_rd_out_sram(addr), .sram_rdata(sram_rdata),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .done(done)
  );

  image_out_sram #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(19'h7FFFF)) dut_w (
    .wclk(wclk), .rst(rst), .enable(enable_w),
    .selec_out_sram(w_selec), .read_out_sram(w_rd), .write_out_sram(w_wr),
    .addr_rd_out_sram(w_addr), .sram_rdata(w_sram_rdata),
    .pix_data(w_data), .pix_x(w_x), .pix_y(w_y), .pix_valid(w_valid),
    .pix_ready(pix_ready), .pix_last(w_last), .busy(w_busy), .done(w_done)
  );

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (all_out !== 72'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else passes++;
    checks++;
    if (w_all_out !== 72'd0) $display("FAIL reset_outputs_w: got %h want 0", w_all_out);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (all_out !== 72'd0) $display("FAIL idle_outputs: got %h want 0", all_out);
    else passes++;
    $display("reset: outputs=%h", all_out);
  endtask

  task automatic test_frame;
    int lat, n, cyc, gaps;
    logic [33:0] exp_vec;
    pix_ready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if ({busy, selec, rd, addr} !== {3'b111, 19'd0})
      $display("FAIL first_read: busy/selec/rd/addr got %b%b%b/%h want 111/00000", busy, selec, rd, addr);
    else passes++;
    lat = 0;
    while (!pix_valid && lat < 10) begin tick(); lat++; end
    checks++;
    if (lat !== 3) $display("FAIL first_valid_latency: got %0d want 3", lat);
    else passes++;
    n = 0; cyc = 0; gaps = 0;
    while (n < N && cyc < 200) begin
      if (pix_valid) begin
        exp_vec = {16'(n), 9'(n % W), 8'(n / W), (n == N - 1)};
        checks++;
        if ({pix_data, pix_x, pix_y, pix_last} !== exp_vec)
          $display("FAIL frame_pixel%0d: got %h want %h", n, {pix_data, pix_x, pix_y, pix_last}, exp_vec);
        else passes++;
        n++;
      end else gaps++;
      tick(); cyc++;
    end
    checks++;
    if (n !== N || gaps !== 0) $display("FAIL frame_count: pixels %0d gaps %0d want %0d 0", n, gaps, N);
    else passes++;
    checks++;
    if ({done, busy} !== 2'b10) $display("FAIL done_pulse: done/busy got %b%b want 10", done, busy);
    else passes++;
    tick();
    checks++;
    if ({done, busy, pix_valid} !== 3'b000) $display("FAIL after_done: done/busy/valid got %b%b%b want 000", done, busy, pix_valid);
    else passes++;
    $display("frame: %0d pixels, latency %0d, gaps %0d", n, lat, gaps);
  endtask

  task automatic test_stall;
    int reads, n, cyc, max_cnt, dones;
    logic hold;
    logic [33:0] prev_vec;
    pix_ready = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      reads += int'(rd);
      tick();
    end
    checks++;
    if (reads !== 4) $display("FAIL stall_reads: got %0d want 4", reads);
    else passes++;
    checks++;
    if ({selec, rd, pix_valid, pix_data} !== {3'b001, 16'h0000})
      $display("FAIL stall_idle_strobes: selec/rd/valid/data got %b%b%b/%h want 001/0000", selec, rd, pix_valid, pix_data);
    else passes++;
    n = 0; cyc = 0; max_cnt = 0; dones = 0; hold = 1'b0; prev_vec = '0;
    while (n < N && cyc < 600) begin
      pix_ready = 1'($urandom_range(0, 1));
      if (hold) begin
        checks++;
        if ({pix_data, pix_x, pix_y, pix_last} !== prev_vec)
          $display("FAIL stall_stable: got %h want %h", {pix_data, pix_x, pix_y, pix_last}, prev_vec);
        else passes++;
      end
      if (pix_valid && pix_ready) begin
        checks++;
        if ({pix_data, pix_x, pix_y} !== {16'(n), 9'(n % W), 8'(n / W)})
          $display("FAIL stall_pixel%0d: got %h/%0d/%0d want %h", n, pix_data, pix_x, pix_y, 16'(n));
        else passes++;
        n++;
      end
      hold = pix_valid && !pix_ready;
      prev_vec = {pix_data, pix_x, pix_y, pix_last};
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      dones += int'(done);
      tick(); cyc++;
    end
    pix_ready = 1'b1;
    dones += int'(done);
    tick();
    checks++;
    if (n !== N || dones !== 1 || max_cnt > 4)
      $display("FAIL stall_summary: pixels %0d dones %0d max_count %0d want %0d 1 <=4", n, dones, max_cnt, N);
    else passes++;
    $display("stall: %0d reads while blocked, %0d pixels, max fifo %0d", reads, n, max_cnt);
  endtask

  task automatic test_reset_mid;
    int n, cyc, dones, lat;
    pix_ready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0; cyc = 0;
    while (cyc < 100) begin
      if (pix_valid) begin
        if (n == 10) break;
        n++;
      end
      tick(); cyc++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (all_out !== 72'd0) $display("FAIL midreset_outputs: got %h want 0", all_out);
    else passes++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      dones += int'(done) + int'(busy);
      tick();
    end
    checks++;
    if (dones !== 0) $display("FAIL midreset_no_done: done/busy cycles %0d want 0", dones);
    else passes++;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if ({selec, addr} !== {1'b1, 19'd0}) $display("FAIL restart_addr: selec/addr got %b/%h want 1/00000", selec, addr);
    else passes++;
    lat = 0;
    while (!pix_valid && lat < 10) begin tick(); lat++; end
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y} !== {1'b1, 33'd0})
      $display("FAIL restart_first_pixel: valid/data/x/y got %b/%h/%0d/%0d want 1/0000/0/0", pix_valid, pix_data, pix_x, pix_y);
    else passes++;
    n = 0; cyc = 0;
    while (!done && cyc < 200) begin
      n += int'(pix_valid);
      tick(); cyc++;
    end
    checks++;
    if (!done || n !== N) $display("FAIL restart_frame: done %b pixels %0d want 1 %0d", done, n, N);
    else passes++;
    tick();
    $display("reset_mid: restart frame %0d pixels", n);
  endtask

  task automatic test_enable_ignored;
    int pops, dones;
    pix_ready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    pops = 0; dones = 0;
    for (int i = 0; i < 150; i++) begin
      enable = (i == 5 || i == 20);
      pops += int'(pix_valid);
      dones += int'(done);
      tick();
    end
    enable = 1'b0;
    checks++;
    if (pops !== N || dones !== 1) $display("FAIL enable_ignored: pixels %0d dones %0d want %0d 1", pops, dones, N);
    else passes++;
    $display("enable_ignored: %0d pixels, %0d done pulses", pops, dones);
  endtask

  task automatic test_back_to_back;
    int n, dones, cyc;
    pix_ready = 1'b1;
    enable = 1'b1;
    n = 0; dones = 0; cyc = 0;
    while (cyc < 300) begin
      if (pix_valid) begin
        checks++;
        if (pix_data !== 16'(n % N)) $display("FAIL b2b_pixel%0d: got %h want %h", n, pix_data, 16'(n % N));
        else passes++;
        n++;
      end
      dones += int'(done);
      if (dones == 2) break;
      tick(); cyc++;
    end
    enable = 1'b0;
    tick(); tick();
    checks++;
    if (dones !== 2 || n !== 2 * N || busy !== 1'b0)
      $display("FAIL b2b_frames: dones %0d pixels %0d busy %b want 2 %0d 0", dones, n, busy, 2 * N);
    else passes++;
    $display("back_to_back: %0d frames, %0d pixels", dones, n);
  endtask

  task automatic test_wrap;
    int n, cyc;
    logic [18:0] a;
    pix_ready = 1'b1;
    enable_w = 1'b1;
    tick();
    enable_w = 1'b0;
    checks++;
    if ({w_rd, w_addr} !== {1'b1, 19'h7FFFF}) $display("FAIL wrap_addr0: rd/addr got %b/%h want 1/7ffff", w_rd, w_addr);
    else passes++;
    tick();
    checks++;
    if ({w_rd, w_addr} !== {1'b1, 19'h00000}) $display("FAIL wrap_addr1: rd/addr got %b/%h want 1/00000", w_rd, w_addr);
    else passes++;
    n = 0; cyc = 0;
    while (!w_done && cyc < 200) begin
      if (w_valid) begin
        a = 19'h7FFFF + 19'(n);
        checks++;
        if ({w_data, w_x, w_y, w_last} !== {a[15:0], 9'(n % W), 8'(n / W), (n == N - 1)})
          $display("FAIL wrap_pixel%0d: got %h/%0d/%0d/%b want %h", n, w_data, w_x, w_y, w_last, a[15:0]);
        else passes++;
        n++;
      end
      tick(); cyc++;
    end
    checks++;
    if (!w_done || n !== N || w_wr !== 1'b0) $display("FAIL wrap_frame: done %b pixels %0d want 1 %0d", w_done, n, N);
    else passes++;
    tick();
    $display("wrap: %0d pixels", n);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; enable_w = 1'b0; pix_ready = 1'b0;
    test_reset();
    test_frame();
    test_stall();
    test_reset_mid();
    test_enable_ignored();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
